// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump FSM state type used by the
// debug/trace register snapshot logic.
package regfile_pkg;

  localparam int        REG_COUNT = 32;
  localparam logic [4:0] XZR_IDX  = 5'd31;
  localparam int        REG_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Valid/ready stream carrying one {index, data} register beat per transfer.
interface regfile_dumper_if #(
  parameter int N = regfile_pkg::REG_W
);

  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_idx;
  logic [N-1:0] out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regfile_dumper.sv
// Walks X0..X(NREGS-1) through a spare regfile read port and streams each
// registered value out as an {index, data} beat.
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter int N     = REG_W,
  parameter int NREGS = REG_COUNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [4:0]           rf_ra,
  input  logic [N-1:0]         rf_rd,
  regfile_dumper_if.master     dump,
  output logic                 busy,
  output logic                 done
);

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  dump_state_t  state;
  logic [4:0]   idx;
  logic [4:0]   beat_idx;
  logic [N-1:0] beat_data;

  // The walk ends on an explicit compare against the last index, so idx never
  // needs to wrap; the beat registers only load in READ, keeping a stalled
  // beat stable for as long as the consumer holds off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 5'd0;
      beat_idx  <= 5'd0;
      beat_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= 5'd0;
            state <= READ;
          end
        end
        READ: begin
          beat_data <= rf_rd;
          beat_idx  <= idx;
          state     <= SEND;
        end
        SEND: begin
          if (dump.out_ready) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The regfile ignores the address outside READ, so it simply follows idx.
  assign rf_ra = idx;

  assign dump.out_valid = (state == SEND);
  assign dump.out_idx   = beat_idx;
  assign dump.out_data  = beat_data;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: a behavioural regfile feeds the spare
// read port while a monitor checks every accepted beat and done pulse.
module tb_regfile_dumper;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rf_ra;
  logic [63:0] rf_rd;
  logic        busy;
  logic        done;

  regfile_dumper_if #(.N(64)) dump_bus ();

  regfile_dumper #(.N(64), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rf_ra (rf_ra),
    .rf_rd (rf_rd),
    .dump  (dump_bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] rf [32];
  logic [63:0] ref_rf [32];
  int          stall_plan [32];

  assign rf_rd = rf[rf_ra];

  beat_t exp_q [$];
  int    done_q [$];

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Consumer: holds out_ready low for stall_plan[beat] cycles at the start of each beat.
  initial begin
    int   beat_no;
    int   stall_left;
    logic accepted;
    beat_no = 0;
    stall_left = 0;
    dump_bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      accepted = dump_bus.out_valid && dump_bus.out_ready && !reset;
      @(posedge clk);
      #1;
      if (!busy) begin
        beat_no = 0;
        stall_left = stall_plan[0];
      end else if (accepted) begin
        beat_no++;
        stall_left = (beat_no < 32) ? stall_plan[beat_no] : 0;
      end
      if (dump_bus.out_valid && stall_left > 0) begin
        dump_bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        dump_bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and every done pulse.
  initial begin
    logic        held;
    logic [4:0]  h_idx;
    logic [63:0] h_data;
    beat_t       e;
    int          dc;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("stall_valid", dump_bus.out_valid, 1'b1);
          checkOutput("stall_idx", dump_bus.out_idx, h_idx);
          checkOutput("stall_data", dump_bus.out_data, h_data);
        end
        if (dump_bus.out_valid) begin
          checkOutput("busy_in_send", busy, 1'b1);
          if (dump_bus.out_ready) begin
            checkOutput("beat_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              checkOutput("beat_idx", dump_bus.out_idx, e.idx);
              checkOutput("beat_data", dump_bus.out_data, e.data);
            end
            held = 1'b0;
          end else begin
            held = 1'b1;
            h_idx = dump_bus.out_idx;
            h_data = dump_bus.out_data;
          end
        end
        if (done) begin
          checkOutput("done_pending", done_q.size() != 0, 1'b1);
          if (done_q.size() != 0) begin
            dc = done_q.pop_front();
            checkOutput("done_cycle", cyc, dc);
          end
        end
      end
    end
  end

  task automatic set_reg(input logic [4:0] a, input logic [63:0] d);
    if (a != 5'd31) rf[a] = d;
    ref_rf[a] = d;
  endtask

  task automatic clear_plan();
    foreach (stall_plan[i]) stall_plan[i] = 0;
  endtask

  // One dump: optional start pulses, one optional mid-dump write, optional reset.
  task automatic applyStimulus(input int p1, input int p2, input int p3,
                               input int wr_t, input logic [4:0] wr_a,
                               input logic [63:0] wr_d, input int rst_t);
    int    c;
    int    total;
    int    read_t;
    beat_t b;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    c = cyc;
    total = 0;
    // A register's beat reflects the regfile as of its READ cycle.
    for (int i = 0; i < 32; i++) begin
      read_t = 1 + 2 * i + total;
      b.idx = 5'(i);
      if (i == 31) b.data = 64'd0;
      else if (wr_t >= 0 && int'(wr_a) == i && wr_t <= read_t) b.data = wr_d;
      else b.data = ref_rf[i];
      exp_q.push_back(b);
      total += stall_plan[i];
    end
    done_q.push_back(c + 65 + total);
    start = 1'b1;
    for (int t = 1; t <= 68 + total; t++) begin
      @(posedge clk);
      #2;
      start = (t == p1 || t == p2 || t == p3);
      if (t == wr_t && wr_a != 5'd31) rf[wr_a] = wr_d;
      if (t == rst_t) begin
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_valid", dump_bus.out_valid, 1'b0);
        checkOutput("rst_mid_busy", busy, 1'b0);
        checkOutput("rst_mid_done", done, 1'b0);
        checkOutput("rst_mid_idx", dump_bus.out_idx, 5'd0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (70) @(posedge clk);
        break;
      end
    end
    start = 1'b0;
    if (wr_t >= 0) ref_rf[wr_a] = wr_d;
    checkOutput("beats_left", exp_q.size(), 0);
    checkOutput("done_left", done_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_plan();
    for (int i = 0; i < 32; i++) begin
      rf[i] = (i == 31) ? 64'd0 : 64'(i);
      ref_rf[i] = (i == 31) ? 64'd0 : 64'(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", dump_bus.out_valid, 1'b0);
    checkOutput("rst_idx", dump_bus.out_idx, 5'd0);
    checkOutput("rst_data", dump_bus.out_data, 64'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_ra", rf_ra, 5'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    applyStimulus(-1, -1, -1, -1, 5'd0, 64'd0, -1);

    clear_plan();
    stall_plan[7] = 3;
    applyStimulus(-1, -1, -1, -1, 5'd0, 64'd0, -1);
    clear_plan();

    applyStimulus(-1, -1, -1, 7, 5'd10, 64'hDEAD, -1);
    set_reg(5'd10, 64'd10);
    applyStimulus(-1, -1, -1, 22, 5'd10, 64'hDEAD, -1);
    set_reg(5'd10, 64'd10);

    applyStimulus(10, 42, 65, -1, 5'd0, 64'd0, -1);

    applyStimulus(-1, -1, -1, -1, 5'd0, 64'd0, 26);
    applyStimulus(-1, -1, -1, -1, 5'd0, 64'd0, -1);

    set_reg(5'd31, 64'h1234);
    applyStimulus(-1, -1, -1, -1, 5'd0, 64'd0, -1);

    for (int r = 0; r < 3; r++) begin
      foreach (stall_plan[i]) stall_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int k = 0; k < 8; k++) set_reg(5'($urandom_range(0, 31)), {$urandom, $urandom});
      applyStimulus(-1, -1, -1, int'($urandom_range(2, 60)), 5'($urandom_range(0, 31)),
                    {$urandom, $urandom}, -1);
    end
    clear_plan();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
